// File: rtl/bresenham_pkg.sv
// Shared types for the octant line walker: FSM states, octant flags and
// the width of the signed coordinate-difference datapath.
package bresenham_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WALK
    } state_t;

    typedef struct packed {
        logic flip_x;
        logic flip_y;
        logic swap;
    } oct_flags_t;

    // One bit wider than the widest coordinate so x1-x0 / y1-y0 never wrap.
    function automatic int d_w(input int x_w, input int y_w);
        return ((x_w > y_w) ? x_w : y_w) + 1;
    endfunction

endpackage

// File: rtl/octant_map.sv
// Maps a normalised (major, minor) walk position back into the real grid
// using the octant flags and the line's start point.
module octant_map
    import bresenham_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int D_W = d_w(X_W, Y_W)
) (
    input  logic [D_W-1:0] i,
    input  logic [D_W-1:0] j,
    input  oct_flags_t     flags,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    output logic [X_W-1:0] cell_x,
    output logic [Y_W-1:0] cell_y
);

    logic [D_W-1:0] a;
    logic [D_W-1:0] b;
    logic           unused_bits;

    always_comb begin
        a = flags.swap ? j : i;
        b = flags.swap ? i : j;
        cell_x = flags.flip_x ? (x0 - a[X_W-1:0]) : (x0 + a[X_W-1:0]);
        cell_y = flags.flip_y ? (y0 - b[Y_W-1:0]) : (y0 + b[Y_W-1:0]);
    end

    // Offsets never exceed the coordinate range, so the upper bits are dead.
    assign unused_bits = ^{a[D_W-1:X_W], b[D_W-1:Y_W]};

endmodule

// File: rtl/octant_line_walker.sv
// Bresenham line walker: accepts a segment request and streams every grid
// cell from (x0,y0) to (x1,y1) over a valid/ready interface.
module octant_line_walker
    import bresenham_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic           abort,
    output logic           cell_valid,
    input  logic           cell_ready,
    output logic [X_W-1:0] cell_x,
    output logic [Y_W-1:0] cell_y,
    output logic           cell_last,
    output logic           busy
);

    localparam int D_W = d_w(X_W, Y_W);

    state_t                state;
    state_t                state_next;
    logic [X_W-1:0]        x0_r;
    logic [X_W-1:0]        x1_r;
    logic [Y_W-1:0]        y0_r;
    logic [Y_W-1:0]        y1_r;
    oct_flags_t            flags;
    logic [D_W-1:0]        i;
    logic [D_W-1:0]        j;
    logic [D_W-1:0]        dmaj;
    logic [D_W-1:0]        dmin;
    logic signed [D_W+1:0] err;
    logic signed [D_W-1:0] dx;
    logic signed [D_W-1:0] dy;
    logic [D_W-1:0]        adx;
    logic [D_W-1:0]        ady;
    logic [D_W-1:0]        maj;
    logic [D_W-1:0]        mn;
    logic                  at_end;
    logic                  start_fire;
    logic                  cell_fire;

    assign dx  = $signed({{(D_W-X_W){1'b0}}, x1_r}) - $signed({{(D_W-X_W){1'b0}}, x0_r});
    assign dy  = $signed({{(D_W-Y_W){1'b0}}, y1_r}) - $signed({{(D_W-Y_W){1'b0}}, y0_r});
    assign adx = dx[D_W-1] ? $unsigned(-dx) : $unsigned(dx);
    assign ady = dy[D_W-1] ? $unsigned(-dy) : $unsigned(dy);
    assign maj = (ady > adx) ? ady : adx;
    assign mn  = (ady > adx) ? adx : ady;

    assign at_end      = (i == dmaj);
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign cell_valid  = (state == WALK);
    assign cell_last   = cell_valid && at_end;
    assign start_fire  = (state == IDLE) && start_valid && !abort;
    assign cell_fire   = (state == WALK) && cell_ready && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort overrides every other transition, including a pending start.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_valid) state_next = SETUP;
                SETUP:   state_next = WALK;
                WALK:    if (cell_ready && at_end) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_r  <= '0;
            x1_r  <= '0;
            y0_r  <= '0;
            y1_r  <= '0;
            flags <= '0;
            i     <= '0;
            j     <= '0;
            dmaj  <= '0;
            dmin  <= '0;
            err   <= '0;
        end else begin
            if (start_fire) begin
                x0_r <= x0;
                x1_r <= x1;
                y0_r <= y0;
                y1_r <= y1;
            end
            if (state == SETUP) begin
                flags.flip_x <= dx[D_W-1];
                flags.flip_y <= dy[D_W-1];
                flags.swap   <= (ady > adx);
                dmaj <= maj;
                dmin <= mn;
                i    <= '0;
                j    <= '0;
                err  <= $signed({1'b0, mn, 1'b0}) - $signed({2'b00, maj});
            end else if (cell_fire && !at_end) begin
                i <= i + D_W'(1);
                // Strictly positive error steps the minor axis; ties stay put.
                if (!err[D_W+1] && (err != '0)) begin
                    j   <= j + D_W'(1);
                    err <= err + $signed({1'b0, dmin, 1'b0}) - $signed({1'b0, dmaj, 1'b0});
                end else begin
                    err <= err + $signed({1'b0, dmin, 1'b0});
                end
            end
        end
    end

    octant_map #(
        .X_W (X_W),
        .Y_W (Y_W),
        .D_W (D_W)
    ) u_map (
        .i      (i),
        .j      (j),
        .flags  (flags),
        .x0     (x0_r),
        .y0     (y0_r),
        .cell_x (cell_x),
        .cell_y (cell_y)
    );

endmodule

// File: tb/tb_octant_line_walker.sv
// Self-checking bench for octant_line_walker: directed and random lines
// compared against a closed-form rounding model of the ideal line.
module tb_octant_line_walker;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic           abort;
    logic           cell_valid;
    logic           cell_ready;
    logic [X_W-1:0] cell_x;
    logic [Y_W-1:0] cell_y;
    logic           cell_last;
    logic           busy;

    int checks = 0;
    int passes = 0;
    int got_x[$];
    int got_y[$];
    int got_last[$];
    int stall_errs;
    int latency;
    int ready_at_start;
    int timed_out;

    always #5 clk = ~clk;

    octant_line_walker #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .x0          (x0),
        .x1          (x1),
        .y0          (y0),
        .y1          (y1),
        .abort       (abort),
        .cell_valid  (cell_valid),
        .cell_ready  (cell_ready),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .cell_last   (cell_last),
        .busy        (busy)
    );

    // Reference: the k-th cell of the ideal line, minor offset = k*dmin/dmaj
    // rounded to nearest with exact halves rounded down.
    function automatic int ref_len(input int ax0, input int ay0, input int ax1, input int ay1);
        int adx;
        int ady;
        adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        return ((adx > ady) ? adx : ady) + 1;
    endfunction

    function automatic void ref_cell(input int ax0, input int ay0, input int ax1, input int ay1,
                                     input int k, output int ex, output int ey);
        int adx;
        int ady;
        int dmaj;
        int dmin;
        int minor;
        int sx;
        int sy;
        adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        dmaj = (ady > adx) ? ady : adx;
        dmin = (ady > adx) ? adx : ady;
        minor = (dmaj == 0) ? 0 : (2 * k * dmin + dmaj - 1) / (2 * dmaj);
        sx = (ady > adx) ? minor : k;
        sy = (ady > adx) ? k : minor;
        ex = (ax1 < ax0) ? ax0 - sx : ax0 + sx;
        ey = (ay1 < ay0) ? ay0 - sy : ay0 + sy;
    endfunction

    // Drives one request and records every accepted cell; cut_at>0 fires
    // abort (or rst) while the cut_at-th cell is being offered.
    task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1,
                                 input int ready_pct, input int cut_at, input bit cut_rst);
        logic           prev_stalled;
        logic [X_W-1:0] px;
        logic [Y_W-1:0] py;
        logic           pl;
        int             cycles;
        bit             done;
        got_x.delete();
        got_y.delete();
        got_last.delete();
        stall_errs = 0;
        latency = -1;
        timed_out = 0;
        @(negedge clk);
        ready_at_start = int'(start_ready);
        start_valid = 1'b1;
        x0 = X_W'(ax0);
        y0 = Y_W'(ay0);
        x1 = X_W'(ax1);
        y1 = Y_W'(ay1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        x0 = X_W'($urandom);
        y0 = Y_W'($urandom);
        x1 = X_W'($urandom);
        y1 = Y_W'($urandom);
        cycles = 0;
        done = 1'b0;
        prev_stalled = 1'b0;
        px = '0;
        py = '0;
        pl = 1'b0;
        while (!done && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (cell_valid === 1'b1 && latency < 0) latency = cycles;
            if (prev_stalled && (cell_valid !== 1'b1 || cell_x !== px || cell_y !== py || cell_last !== pl))
                stall_errs++;
            cell_ready = ($urandom_range(99) < ready_pct);
            if (cell_valid === 1'b1 && cell_ready && cut_at == got_x.size() + 1) begin
                if (cut_rst) rst = 1'b1;
                else abort = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                abort = 1'b0;
                cell_ready = 1'b0;
                done = 1'b1;
            end else begin
                if (cell_valid === 1'b1 && cell_ready) begin
                    got_x.push_back(int'(cell_x));
                    got_y.push_back(int'(cell_y));
                    got_last.push_back(int'(cell_last));
                end
                prev_stalled = (cell_valid === 1'b1) && !cell_ready;
                px = cell_x;
                py = cell_y;
                pl = cell_last;
                if (cell_valid === 1'b1 && cell_ready && cell_last === 1'b1) begin
                    @(posedge clk);
                    #1;
                    cell_ready = 1'b0;
                    done = 1'b1;
                end
            end
        end
        if (!done) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b0;
        abort = 1'b0;
        cell_ready = 1'b0;
        x0 = '0;
        y0 = '0;
        x1 = '0;
        y1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({start_ready, busy, cell_valid, cell_last} !== 4'b1000)
            $display("[TB] FAIL reset_flags: got %b expected 1000", {start_ready, busy, cell_valid, cell_last});
        else passes++;
        checks++;
        if (cell_x !== '0 || cell_y !== '0)
            $display("[TB] FAIL reset_cell: got (%0d,%0d) expected (0,0)", cell_x, cell_y);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1)
            $display("[TB] FAIL reset_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, start_ready);
        else passes++;
    endtask

    task automatic test_shallow();
        int ex[6] = '{0, 1, 2, 3, 4, 5};
        int ey[6] = '{0, 0, 1, 1, 2, 2};
        int gx;
        int gy;
        int gl;
        applyStimulus(0, 0, 5, 2, 100, 0, 1'b0);
        checks++;
        if (latency !== 2) $display("[TB] FAIL shallow_latency: got %0d expected 2", latency);
        else passes++;
        checks++;
        if (got_x.size() !== 6) $display("[TB] FAIL shallow_count: got %0d expected 6", got_x.size());
        else passes++;
        for (int k = 0; k < 6; k++) begin
            gx = (k < got_x.size()) ? got_x[k] : -1;
            gy = (k < got_y.size()) ? got_y[k] : -1;
            gl = (k < got_last.size()) ? got_last[k] : -1;
            checks++;
            if (gx !== ex[k] || gy !== ey[k] || gl !== int'(k == 5))
                $display("[TB] FAIL shallow_cell%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         k, gx, gy, gl, ex[k], ey[k], int'(k == 5));
            else passes++;
        end
    endtask

    task automatic test_steep_flip();
        int ex[6] = '{10, 10, 9, 9, 8, 8};
        int ey[6] = '{10, 9, 8, 7, 6, 5};
        int gx;
        int gy;
        int gl;
        applyStimulus(10, 10, 8, 5, 60, 0, 1'b0);
        checks++;
        if (got_x.size() !== 6) $display("[TB] FAIL steep_count: got %0d expected 6", got_x.size());
        else passes++;
        checks++;
        if (stall_errs !== 0) $display("[TB] FAIL steep_stall: got %0d changes expected 0", stall_errs);
        else passes++;
        for (int k = 0; k < 6; k++) begin
            gx = (k < got_x.size()) ? got_x[k] : -1;
            gy = (k < got_y.size()) ? got_y[k] : -1;
            gl = (k < got_last.size()) ? got_last[k] : -1;
            checks++;
            if (gx !== ex[k] || gy !== ey[k] || gl !== int'(k == 5))
                $display("[TB] FAIL steep_cell%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                         k, gx, gy, gl, ex[k], ey[k], int'(k == 5));
            else passes++;
        end
    endtask

    task automatic test_degenerate();
        applyStimulus(7, 3, 7, 3, 100, 0, 1'b0);
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL degenerate_idle: got ready=%b busy=%b expected ready=1 busy=0", start_ready, busy);
        else passes++;
        checks++;
        if (got_x.size() !== 1 || got_x[0] !== 7 || got_y[0] !== 3 || got_last[0] !== 1)
            $display("[TB] FAIL degenerate_cell: got %0d cells first (%0d,%0d,%0d) expected 1 cell (7,3,1)",
                     got_x.size(), (got_x.size() > 0) ? got_x[0] : -1,
                     (got_y.size() > 0) ? got_y[0] : -1, (got_last.size() > 0) ? got_last[0] : -1);
        else passes++;
        checks++;
        if (latency !== 2) $display("[TB] FAIL degenerate_latency: got %0d expected 2", latency);
        else passes++;
    endtask

    task automatic test_long_stall();
        int gx;
        int gy;
        int gl;
        applyStimulus(0, 0, 255, 0, 50, 0, 1'b0);
        checks++;
        if (timed_out !== 0) $display("[TB] FAIL long_timeout: got %0d expected 0", timed_out);
        else passes++;
        checks++;
        if (got_x.size() !== 256) $display("[TB] FAIL long_count: got %0d expected 256", got_x.size());
        else passes++;
        checks++;
        if (stall_errs !== 0) $display("[TB] FAIL long_stall: got %0d changes expected 0", stall_errs);
        else passes++;
        for (int k = 0; k < 256; k++) begin
            gx = (k < got_x.size()) ? got_x[k] : -1;
            gy = (k < got_y.size()) ? got_y[k] : -1;
            gl = (k < got_last.size()) ? got_last[k] : -1;
            checks++;
            if (gx !== k || gy !== 0 || gl !== int'(k == 255))
                $display("[TB] FAIL long_cell%0d: got (%0d,%0d,%0d) expected (%0d,0,%0d)",
                         k, gx, gy, gl, k, int'(k == 255));
            else passes++;
        end
    endtask

    task automatic test_cut_walk(input bit use_rst);
        int seen_valid;
        applyStimulus(0, 0, 9, 9, 100, 4, use_rst);
        checks++;
        if (got_x.size() !== 3) $display("[TB] FAIL cut%0d_count: got %0d expected 3", use_rst, got_x.size());
        else passes++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= got_x.size() || got_x[k] !== k || got_y[k] !== k)
                $display("[TB] FAIL cut%0d_cell%0d: got (%0d,%0d) expected (%0d,%0d)", use_rst, k,
                         (k < got_x.size()) ? got_x[k] : -1, (k < got_y.size()) ? got_y[k] : -1, k, k);
            else passes++;
        end
        checks++;
        if ({cell_valid, busy, start_ready} !== 3'b001)
            $display("[TB] FAIL cut%0d_state: got %b expected 001", use_rst, {cell_valid, busy, start_ready});
        else passes++;
        if (use_rst) begin
            checks++;
            if (cell_x !== '0 || cell_y !== '0)
                $display("[TB] FAIL cut_rst_cell: got (%0d,%0d) expected (0,0)", cell_x, cell_y);
            else passes++;
        end
        cell_ready = 1'b1;
        seen_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (cell_valid !== 1'b0) seen_valid++;
        end
        cell_ready = 1'b0;
        checks++;
        if (seen_valid !== 0) $display("[TB] FAIL cut%0d_quiet: got %0d valid cycles expected 0", use_rst, seen_valid);
        else passes++;
    endtask

    task automatic test_abort_vs_start();
        @(negedge clk);
        start_valid = 1'b1;
        abort = 1'b1;
        x0 = 8'd1;
        y0 = 7'd1;
        x1 = 8'd20;
        y1 = 7'd4;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1)
            $display("[TB] FAIL abort_start: got busy=%b ready=%b expected busy=0 ready=1", busy, start_ready);
        else passes++;
    endtask

    task automatic test_random_lines();
        int ax0;
        int ay0;
        int ax1;
        int ay1;
        int n;
        int ex;
        int ey;
        int bad;
        for (int t = 0; t < 12; t++) begin
            ax0 = int'($urandom_range(255));
            ay0 = int'($urandom_range(127));
            ax1 = int'($urandom_range(255));
            ay1 = int'($urandom_range(127));
            n = ref_len(ax0, ay0, ax1, ay1);
            applyStimulus(ax0, ay0, ax1, ay1, 75, 0, 1'b0);
            checks++;
            if (got_x.size() !== n || latency !== 2 || stall_errs !== 0)
                $display("[TB] FAIL rand%0d_shape: got n=%0d lat=%0d stall=%0d expected n=%0d lat=2 stall=0",
                         t, got_x.size(), latency, stall_errs, n);
            else passes++;
            bad = 0;
            for (int k = 0; k < n && k < got_x.size(); k++) begin
                ref_cell(ax0, ay0, ax1, ay1, k, ex, ey);
                if (got_x[k] !== ex || got_y[k] !== ey || got_last[k] !== int'(k == n - 1)) begin
                    if (bad == 0)
                        $display("[TB] FAIL rand%0d_cell%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                 t, k, got_x[k], got_y[k], got_last[k], ex, ey, int'(k == n - 1));
                    bad++;
                end
            end
            checks++;
            if (bad == 0) passes++;
        end
    endtask

    task automatic test_back_to_back();
        int ex;
        int ey;
        applyStimulus(3, 100, 40, 90, 100, 0, 1'b0);
        checks++;
        if (got_x.size() !== 38) $display("[TB] FAIL b2b_first_count: got %0d expected 38", got_x.size());
        else passes++;
        applyStimulus(200, 5, 190, 60, 100, 0, 1'b0);
        checks++;
        if (ready_at_start !== 1) $display("[TB] FAIL b2b_idle_ready: got %0d expected 1", ready_at_start);
        else passes++;
        checks++;
        if (got_x.size() !== 56 || latency !== 2)
            $display("[TB] FAIL b2b_second: got n=%0d lat=%0d expected n=56 lat=2", got_x.size(), latency);
        else passes++;
        ref_cell(200, 5, 190, 60, 27, ex, ey);
        checks++;
        if (got_x.size() < 28 || got_x[27] !== ex || got_y[27] !== ey)
            $display("[TB] FAIL b2b_mid_cell: got (%0d,%0d) expected (%0d,%0d)",
                     (got_x.size() > 27) ? got_x[27] : -1, (got_y.size() > 27) ? got_y[27] : -1, ex, ey);
        else passes++;
    endtask

    task automatic checkOutput();
        $display("%0d/%0d checks passed", passes, checks);
    endtask

    initial begin
        test_reset();
        test_shallow();
        test_steep_flip();
        test_degenerate();
        test_long_stall();
        test_cut_walk(1'b0);
        test_cut_walk(1'b1);
        test_abort_vs_start();
        test_random_lines();
        test_back_to_back();
        checkOutput();
        $finish;
    end

endmodule

// File: doc/octant_line_walker.md
OCTANT_LINE_WALKER -- requirements
Module: octant_line_walker

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter X_W, default 8, x-coordinate width in bits.
REQ-003 Parameter Y_W, default 7, y-coordinate width in bits.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_valid  in  1  line request present.
REQ-007 start_ready  out  1  block can accept a request.
REQ-008 x0, x1  in  X_W  unsigned start and end x.
REQ-009 y0, y1  in  Y_W  unsigned start and end y.
REQ-010 abort  in  1  cancel the current walk.
REQ-011 cell_valid  out  1  cell_x/cell_y/cell_last valid.
REQ-012 cell_ready  in  1  downstream accepts cell.
REQ-013 cell_x  out  X_W, cell_y  out  Y_W, current grid cell.
REQ-014 cell_last  out  1  current cell is the endpoint (x1,y1).
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, SETUP, WALK. Transitions: IDLE->SETUP on start_valid&&start_ready; SETUP->WALK always; WALK->IDLE on a cell_last handshake.
REQ-017 start_ready SHALL be 1 only in IDLE; x0/y0/x1/y1 are captured on the start handshake.
REQ-018 SETUP: dx=x1-x0 and dy=y1-y0 are signed, width max(X_W,Y_W)+1, computed without wrap. flip_x=(dx<0), flip_y=(dy<0), swap=(|dy|>|dx|). dmaj=max(|dx|,|dy|), dmin=min.
REQ-019 Walk runs in normalised space: major index i=0..dmaj, minor index j from 0; err is signed, width D_W+2; initial err=2*dmin-dmaj.
REQ-020 On each accepted cell with i<dmaj: i++; if err>0 (strict), j++ and err+=2*(dmin-dmaj); else err+=2*dmin.
REQ-021 Output mapping: a=swap?j:i, b=swap?i:j; cell_x=x0+(flip_x?-a:a), cell_y=y0+(flip_y?-b:b), truncated to X_W/Y_W.
REQ-022 Exactly dmaj+1 cells SHALL be emitted, first (x0,y0), last (x1,y1); cell_last=(i==dmaj).
REQ-023 Latency: start handshake at cycle T -> cell_valid=1 at T+2. Throughput: 1 cell/cycle when cell_ready is held high.
REQ-024 cell_valid SHALL be 1 throughout WALK. While cell_valid&&!cell_ready, all cell outputs SHALL hold stable.
REQ-025 Degenerate case (x0==x1, y0==y1): exactly one cell with cell_last=1.
REQ-026 abort in any state -> IDLE on the next edge. cell_valid is 0 from that edge onward, and no further cells are emitted. abort has priority over the cell handshake and start in the same cycle.
REQ-027 A new request is accepted only after return to IDLE. Back-to-back requests give one idle cycle (start_ready high) between walks.

Reset
REQ-028 rst SHALL have priority over all inputs, including abort.
REQ-029 On rst, within one edge: state=IDLE, cell_valid=0, cell_last=0, busy=0, start_ready=1.
REQ-030 On rst: cell_x=0, cell_y=0, and i, j, err, flags cleared.
REQ-031 rst mid-walk SHALL discard the walk with no further cells.

Structure
REQ-032 Package bresenham_pkg SHALL hold:
- the state enum;
- the octant flags struct {flip_x, flip_y, swap};
- width helper constant D_W=max(X_W,Y_W)+1 as a function.
REQ-033 Sub-module octant_map (combinational, parametrised X_W/Y_W): maps (i, j, flags, x0, y0) to (cell_x, cell_y). Instantiated once.

Verification
REQ-034 (0,0)->(5,2), cell_ready=1 -> (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); last on 6th cell; first valid at T+2.
REQ-035 (10,10)->(8,5) -> (10,10),(10,9),(9,8),(9,7),(8,6),(8,5); flip_x=flip_y=swap=1.
REQ-036 (7,3)->(7,3) -> single cell (7,3) with cell_last=1; start_ready high the cycle after.
REQ-037 (0,0)->(255,0), cell_ready toggled randomly -> 256 cells x=0..255, y=0; outputs stable while stalled; no cell dropped or duplicated.
REQ-038 (0,0)->(9,9) with abort on the 4th cell -> IDLE next edge, cell_valid=0, exactly 3 cells accepted. Repeat the scenario with rst in place of abort -> same result.
